// File: rtl/axi_lite_rd_arb.sv
// Round-robin AXI4-Lite read arbiter: NUM_SLV_PORTS read masters share one read slave, R returned in order.
// Define AXI_LITE_RD_ARB_R_SPILL_EN to register the R path through a 2-entry spill buffer.
module axi_lite_rd_arb #(
    parameter int unsigned NUM_SLV_PORTS = 4,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MAX_TRANS     = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NUM_SLV_PORTS-1:0][ADDR_WIDTH-1:0] slv_ar_addr_i,
    input  logic [NUM_SLV_PORTS-1:0]                slv_ar_valid_i,
    output logic [NUM_SLV_PORTS-1:0]                slv_ar_ready_o,
    output logic [DATA_WIDTH-1:0]                   slv_r_data_o,
    output logic [1:0]                              slv_r_resp_o,
    output logic [NUM_SLV_PORTS-1:0]                slv_r_valid_o,
    input  logic [NUM_SLV_PORTS-1:0]                slv_r_ready_i,
    output logic [ADDR_WIDTH-1:0]                   mst_ar_addr_o,
    output logic                                    mst_ar_valid_o,
    input  logic                                    mst_ar_ready_i,
    input  logic [DATA_WIDTH-1:0]                   mst_r_data_i,
    input  logic [1:0]                              mst_r_resp_i,
    input  logic                                    mst_r_valid_i,
    output logic                                    mst_r_ready_o
);

    localparam int unsigned IDX_W = (NUM_SLV_PORTS > 1) ? $clog2(NUM_SLV_PORTS) : 1;
    localparam int unsigned PTR_W = (MAX_TRANS > 1) ? $clog2(MAX_TRANS) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_TRANS + 1);

    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] lock_idx_q;
    logic             lock_q;
    logic [IDX_W-1:0] winner;
    logic             full;
    logic             empty;
    logic             ar_hs;
    logic             push;
    logic             pop;

    logic [IDX_W-1:0] fifo_q [MAX_TRANS];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] head;

    // First requesting port at or after the pointer; scanning downwards lets the nearest one win.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_SLV_PORTS-1:0] vld,
                                                 input logic [IDX_W-1:0]         ptr);
        logic [IDX_W-1:0] pick;
        int               c;
        pick = ptr;
        for (int i = NUM_SLV_PORTS - 1; i >= 0; i--) begin
            c = (int'(ptr) + i) % NUM_SLV_PORTS;
            if (vld[c]) pick = IDX_W'(c);
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_SLV_PORTS - 1) ? '0 : idx + IDX_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (int'(ptr) == MAX_TRANS - 1) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full  = (cnt_q == CNT_W'(MAX_TRANS));
    assign empty = (cnt_q == '0);

    // AR arbitration: combinational, grant frozen while a stalled request is pending
    assign winner         = lock_q ? lock_idx_q : rr_pick(slv_ar_valid_i, rr_q);
    assign mst_ar_valid_o = rst_ni & (|slv_ar_valid_i) & ~full;
    assign mst_ar_addr_o  = slv_ar_addr_i[winner];
    assign ar_hs          = mst_ar_valid_o & mst_ar_ready_i;
    assign push           = ar_hs;

    always_comb begin
        slv_ar_ready_o         = '0;
        slv_ar_ready_o[winner] = rst_ni & mst_ar_ready_i & ~full;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (ar_hs) begin
            rr_q   <= idx_inc(winner);
            lock_q <= 1'b0;
        end else if (mst_ar_valid_o) begin
            lock_q     <= 1'b1;
            lock_idx_q <= winner;
        end
    end

    // Grantee index FIFO: one entry per outstanding read, head owns the next R beat
    assign head = fifo_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= winner;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!push && pop) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

`ifdef AXI_LITE_RD_ARB_R_SPILL_EN
    logic [DATA_WIDTH-1:0] spill_data_p1 [2];
    logic [1:0]            spill_resp_p1 [2];
    logic                  spill_wr_q;
    logic                  spill_rd_q;
    logic [1:0]            spill_cnt_q;
    logic                  spill_in;
    logic                  spill_vld;

    // R stage p1: only accept beats that still have an unclaimed FIFO entry behind the buffered ones
    assign spill_vld     = (spill_cnt_q != 2'd0);
    assign mst_r_ready_o = rst_ni & (spill_cnt_q != 2'd2) & (32'(cnt_q) > 32'(spill_cnt_q));
    assign spill_in      = mst_r_valid_i & mst_r_ready_o;
    assign pop           = rst_ni & spill_vld & slv_r_ready_i[head];
    assign slv_r_data_o  = spill_data_p1[spill_rd_q];
    assign slv_r_resp_o  = spill_resp_p1[spill_rd_q];

    always_comb begin
        slv_r_valid_o       = '0;
        slv_r_valid_o[head] = rst_ni & spill_vld;
    end

    always_ff @(posedge clk_i) begin
        if (spill_in) begin
            spill_data_p1[spill_wr_q] <= mst_r_data_i;
            spill_resp_p1[spill_wr_q] <= mst_r_resp_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spill_wr_q  <= 1'b0;
            spill_rd_q  <= 1'b0;
            spill_cnt_q <= 2'd0;
        end else begin
            if (spill_in) spill_wr_q <= ~spill_wr_q;
            if (pop)      spill_rd_q <= ~spill_rd_q;
            if (spill_in && !pop) begin
                spill_cnt_q <= spill_cnt_q + 2'd1;
            end else if (!spill_in && pop) begin
                spill_cnt_q <= spill_cnt_q - 2'd1;
            end
        end
    end

    r_beat_without_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mst_r_valid_i && (32'(cnt_q) <= 32'(spill_cnt_q))));
`else
    assign mst_r_ready_o = rst_ni & ~empty & slv_r_ready_i[head];
    assign pop           = mst_r_valid_i & mst_r_ready_o;
    assign slv_r_data_o  = mst_r_data_i;
    assign slv_r_resp_o  = mst_r_resp_i;

    always_comb begin
        slv_r_valid_o       = '0;
        slv_r_valid_o[head] = rst_ni & ~empty & mst_r_valid_i;
    end

    r_beat_without_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mst_r_valid_i && empty));
`endif

endmodule

// File: tb/tb_axi_lite_rd_arb.sv
// Directed bench for axi_lite_rd_arb: grant order, lock, full throttling, R routing and reset.
module tb_axi_lite_rd_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [N-1:0][AW-1:0] slv_ar_addr_i;
    logic [N-1:0]         slv_ar_valid_i;
    logic [N-1:0]         slv_ar_ready_o;
    logic [DW-1:0]        slv_r_data_o;
    logic [1:0]           slv_r_resp_o;
    logic [N-1:0]         slv_r_valid_o;
    logic [N-1:0]         slv_r_ready_i;
    logic [AW-1:0]        mst_ar_addr_o;
    logic                 mst_ar_valid_o;
    logic                 mst_ar_ready_i;
    logic [DW-1:0]        mst_r_data_i;
    logic [1:0]           mst_r_resp_i;
    logic                 mst_r_valid_i;
    logic                 mst_r_ready_o;

    int vectors = 0;
    int errs    = 0;
    int beat    = 0;
    int sb[$];

    axi_lite_rd_arb #(
        .NUM_SLV_PORTS(N),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MAX_TRANS    (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .slv_ar_addr_i (slv_ar_addr_i),
        .slv_ar_valid_i(slv_ar_valid_i),
        .slv_ar_ready_o(slv_ar_ready_o),
        .slv_r_data_o  (slv_r_data_o),
        .slv_r_resp_o  (slv_r_resp_o),
        .slv_r_valid_o (slv_r_valid_o),
        .slv_r_ready_i (slv_r_ready_i),
        .mst_ar_addr_o (mst_ar_addr_o),
        .mst_ar_valid_o(mst_ar_valid_o),
        .mst_ar_ready_i(mst_ar_ready_i),
        .mst_r_data_i  (mst_r_data_i),
        .mst_r_resp_i  (mst_r_resp_i),
        .mst_r_valid_i (mst_r_valid_i),
        .mst_r_ready_o (mst_r_ready_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ar_expect(input int p);
        chk("ar_valid", mst_ar_valid_o, 1);
        chk("ar_ready_onehot", slv_ar_ready_o, 4'b0001 << p);
        chk("ar_addr", mst_ar_addr_o, slv_ar_addr_i[p]);
        sb.push_back(p);
    endtask

    task automatic drive_r(input logic [31:0] d, input logic [1:0] rsp);
        mst_r_valid_i = 1'b1;
        mst_r_data_i  = d;
        mst_r_resp_i  = rsp;
    endtask

    task automatic r_expect(input logic [31:0] d, input logic [1:0] rsp);
        int p;
        vectors++;
        assert (sb.size() != 0) else begin
            errs++;
            $error("FAIL r_scoreboard: observed empty queue expected pending read");
        end
        if (sb.size() != 0) begin
            p = sb.pop_front();
            chk("r_valid_route", slv_r_valid_o, 4'b0001 << p);
            chk("r_ready", mst_r_ready_o, 1);
            chk("r_data", slv_r_data_o, d);
            chk("r_resp", slv_r_resp_o, rsp);
        end
    endtask

    task automatic r_only();
        logic [31:0] d;
        logic [1:0]  rsp;
        d   = 32'hA500_0000 + 32'(beat);
        rsp = 2'(beat);
        beat++;
        slv_ar_valid_i = '0;
        drive_r(d, rsp);
        #1;
        r_expect(d, rsp);
        tick();
        mst_r_valid_i = 1'b0;
    endtask

    task automatic ar_and_r(input int p);
        logic [31:0] d;
        logic [1:0]  rsp;
        d   = 32'hA500_0000 + 32'(beat);
        rsp = 2'(beat);
        beat++;
        drive_r(d, rsp);
        #1;
        ar_expect(p);
        r_expect(d, rsp);
        tick();
    endtask

    initial begin
        rst_ni         = 1'b0;
        for (int p = 0; p < N; p++) slv_ar_addr_i[p] = 32'h100 + 32'(p * 4);
        slv_ar_valid_i = '1;
        mst_ar_ready_i = 1'b1;
        slv_r_ready_i  = '1;
        mst_r_valid_i  = 1'b0;
        mst_r_data_i   = '0;
        mst_r_resp_i   = '0;

        // reset: outputs gated even with requests pending
        #12;
        chk("rst_mst_ar_valid", mst_ar_valid_o, 0);
        chk("rst_slv_ar_ready", slv_ar_ready_o, 0);
        chk("rst_mst_r_ready", mst_r_ready_o, 0);
        chk("rst_slv_r_valid", slv_r_valid_o, 0);
        slv_ar_valid_i = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // round robin over ports 0,1,3 with overlapping R traffic
        slv_ar_valid_i = 4'b1011;
        #1; ar_expect(0); tick();
        #1; ar_expect(1); tick();
        ar_and_r(3);
        ar_and_r(0);
        ar_and_r(1);
        ar_and_r(3);
        mst_r_valid_i = 1'b0;
        r_only();
        r_only();

        // single port 2 at 0x10
        slv_ar_addr_i[2] = 32'h10;
        slv_ar_valid_i   = 4'b0100;
        #1;
        chk("p2_addr_0x10", mst_ar_addr_o, 32'h10);
        ar_expect(2);
        tick();
        r_only();
        slv_ar_addr_i[2] = 32'h108;

        // lock: port 1 stalled, port 0 joins, grant stays on 1
        slv_ar_valid_i = 4'b0010;
        mst_ar_ready_i = 1'b0;
        #1;
        chk("lock_first_addr", mst_ar_addr_o, slv_ar_addr_i[1]);
        chk("lock_stall_ready", slv_ar_ready_o, 0);
        tick();
        slv_ar_valid_i = 4'b0011;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("lock_held_addr", mst_ar_addr_o, slv_ar_addr_i[1]);
            chk("lock_held_valid", mst_ar_valid_o, 1);
            tick();
        end
        mst_ar_ready_i = 1'b1;
        #1; ar_expect(1); tick();
        slv_ar_valid_i = 4'b0001;
        #1; ar_expect(0); tick();
        r_only();
        r_only();

        // full: four accepted, fifth blocked until an R handshake, no same-cycle bypass
        slv_ar_valid_i = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            #1; ar_expect(3); tick();
        end
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("full_ar_valid", mst_ar_valid_o, 0);
            chk("full_ar_ready", slv_ar_ready_o, 0);
            tick();
        end
        drive_r(32'hA5A5_0001, 2'b01);
        #1;
        chk("full_no_bypass", mst_ar_valid_o, 0);
        r_expect(32'hA5A5_0001, 2'b01);
        tick();
        mst_r_valid_i = 1'b0;
        #1; ar_expect(3); tick();
        for (int c = 0; c < 4; c++) r_only();

        // port 2 back-pressures R: beat held, then delivered
        slv_ar_valid_i = 4'b0100;
        #1; ar_expect(2); tick();
        slv_ar_valid_i = '0;
        slv_r_ready_i  = 4'b1011;
        drive_r(32'hDEAD, 2'b10);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_mst_r_ready", mst_r_ready_o, 0);
            chk("bp_r_valid", slv_r_valid_o, 4'b0100);
            chk("bp_r_data", slv_r_data_o, 32'hDEAD);
            chk("bp_r_resp", slv_r_resp_o, 2'b10);
            tick();
        end
        slv_r_ready_i = '1;
        #1; r_expect(32'hDEAD, 2'b10); tick();
        mst_r_valid_i = 1'b0;

        // reset with three reads outstanding
        slv_ar_valid_i = 4'b0111;
        #1; ar_expect(0); tick();
        #1; ar_expect(1); tick();
        #1; ar_expect(2); tick();
        slv_ar_valid_i = '1;
        drive_r(32'h1234, 2'b00);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_mst_ar_valid", mst_ar_valid_o, 0);
        chk("arst_slv_ar_ready", slv_ar_ready_o, 0);
        chk("arst_mst_r_ready", mst_r_ready_o, 0);
        chk("arst_slv_r_valid", slv_r_valid_o, 0);
        tick();
        chk("arst_hold_ar_valid", mst_ar_valid_o, 0);
        chk("arst_hold_r_valid", slv_r_valid_o, 0);
        mst_r_valid_i  = 1'b0;
        slv_ar_valid_i = '0;
        sb.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        slv_ar_valid_i = '1;
        #1;
        chk("post_rst_r_ready", mst_r_ready_o, 0);
        ar_expect(0);
        tick();
        for (int p = 1; p < 4; p++) begin
            #1; ar_expect(p); tick();
        end
        #1;
        chk("post_rst_full", mst_ar_valid_o, 0);
        tick();
        for (int c = 0; c < 4; c++) r_only();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
